multicycle_ctrl_fsm: RTL

- Moore control FSM that sequences the shared-memory multicycle MIPS datapath: one memory port for instructions and data, one ALU reused for PC increment, branch target and execute.
- Decodes the held instruction-register opcode/funct and drives every datapath enable and mux select.
- Stretches memory states on a ready handshake.
- Counts retired instructions and traps on unsupported encodings.

---
 rtl/multicycle_ctrl_fsm_if.sv | 47 ++++
 rtl/multicycle_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if
//   Bundle between the multicycle MIPS control FSM and its datapath.
//   master : datapath side. It drives the decode inputs and the memory ready,
//            and it receives every enable and mux select.
//   slave  : control FSM side.
//   Signals:
//     i_op_w / i_funct_w : held IR fields (instr[31:26] / instr[5:0])
//     i_zero_w           : ALU zero flag
//     i_mem_ready_w      : shared memory port completes this cycle
//     o_*                : datapath enables, mux selects, ALU op, debug state,
//                          trap flag and retired-instruction count
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       i_op_w;
  logic [5:0]       i_funct_w;
  logic             i_zero_w;
  logic             i_mem_ready_w;
  logic             o_iord_w;
  logic             o_ir_write_w;
  logic             o_pc_en_w;
  logic             o_mem_write_w;
  logic             o_reg_write_w;
  logic             o_mem_to_reg_w;
  logic             o_reg_dst_w;
  logic             o_alu_src_a_w;
  logic [1:0]       o_alu_src_b_w;
  logic [1:0]       o_pc_src_w;
  logic [2:0]       o_alu_control_w;
  logic [3:0]       o_state_w;
  logic             o_trap_w;
  logic [CNT_W-1:0] o_retired_w;

  modport master (
    output i_op_w, i_funct_w, i_zero_w, i_mem_ready_w,
    input  o_iord_w, o_ir_write_w, o_pc_en_w, o_mem_write_w, o_reg_write_w,
           o_mem_to_reg_w, o_reg_dst_w, o_alu_src_a_w, o_alu_src_b_w,
           o_pc_src_w, o_alu_control_w, o_state_w, o_trap_w, o_retired_w
  );

  modport slave (
    input  i_op_w, i_funct_w, i_zero_w, i_mem_ready_w,
    output o_iord_w, o_ir_write_w, o_pc_en_w, o_mem_write_w, o_reg_write_w,
           o_mem_to_reg_w, o_reg_dst_w, o_alu_src_a_w, o_alu_src_b_w,
           o_pc_src_w, o_alu_control_w, o_state_w, o_trap_w, o_retired_w
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Moore control FSM for the shared-memory multicycle MIPS datapath
//   (lw, sw, R-type add/sub/and/or/slt, beq, addi, j).
//   Every datapath control is a decode of the current state. The only
//   exceptions are the fetch strobes, which follow i_mem_ready_w, and the
//   beq PC enable, which follows i_zero_w.
//   Ports:
//     i_clk_w : clock, rising edge
//     i_rst_w : asynchronous active-low reset. It parks the FSM in RST with
//               all strobes low and clears the retired count.
//     bus     : slave side of multicycle_ctrl_fsm_if. It carries the decode
//               inputs and all control and debug outputs.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic                  i_clk_w,
  input  logic                  i_rst_w,
  multicycle_ctrl_fsm_if.slave  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd14,
    S_RST    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] retired;
  logic             retire;

  logic       iord, ir_write, pc_en, mem_write, reg_write, mem_to_reg;
  logic       reg_dst, alu_src_a, trap;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      state   <= S_RST;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    retire      = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_src      = 2'b00;
    alu_control = 3'b000;
    trap        = 1'b0;

    case (state)
      S_RST: state_nxt = S_FETCH;

      // The ALU computes PC+4 while the memory port reads the instruction.
      // IR and PC commit only on the cycle the memory delivers.
      S_FETCH: begin
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = bus.i_mem_ready_w;
        pc_en       = bus.i_mem_ready_w;
        if (bus.i_mem_ready_w) state_nxt = S_DECODE;
      end

      // The branch target PC + (imm<<2) is computed here, ahead of BRANCH.
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (bus.i_op_w)
          OP_RTYPE:     state_nxt = funct_ok(bus.i_funct_w) ? S_EXEC : S_TRAP;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_nxt   = (bus.i_op_w == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (bus.i_mem_ready_w) state_nxt = S_MEMWB;
      end

      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
        retire     = 1'b1;
      end

      // The write strobe stays high for the whole wait, so the memory sees
      // a request that is stable until it reports ready.
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.i_mem_ready_w) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end

      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu(bus.i_funct_w);
        state_nxt   = S_ALUWB;
      end

      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end

      // Compare runs through the ALU. The target latched in DECODE sits in
      // ALUOut, and the PC loads it only if the operands matched.
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = bus.i_zero_w;
        state_nxt   = S_FETCH;
        retire      = 1'b1;
      end

      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_nxt   = S_ADDIWB;
      end

      S_ADDIWB: begin
        reg_write = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end

      S_JUMP: begin
        pc_src    = 2'b10;
        pc_en     = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end

      S_TRAP: trap = 1'b1;

      // Encodings 12/13 are unreachable. If one appears, the FSM parks in
      // TRAP instead of issuing strobes.
      default: state_nxt = S_TRAP;
    endcase
  end

  assign bus.o_iord_w        = iord;
  assign bus.o_ir_write_w    = ir_write;
  assign bus.o_pc_en_w       = pc_en;
  assign bus.o_mem_write_w   = mem_write;
  assign bus.o_reg_write_w   = reg_write;
  assign bus.o_mem_to_reg_w  = mem_to_reg;
  assign bus.o_reg_dst_w     = reg_dst;
  assign bus.o_alu_src_a_w   = alu_src_a;
  assign bus.o_alu_src_b_w   = alu_src_b;
  assign bus.o_pc_src_w      = pc_src;
  assign bus.o_alu_control_w = alu_control;
  assign bus.o_state_w       = state;
  assign bus.o_trap_w        = trap;
  assign bus.o_retired_w     = retired;

endmodule
